uart_link_controller: RTL

//   Host-side counterpart of the UART peripheral's parallel interface. Buffers outbound bytes and

---
 rtl/uart_link_pkg.sv | 16 +
 rtl/uart_link_if.sv | 37 +++
 rtl/uart_byte_fifo.sv | 45 ++++
 rtl/uart_link_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared widths and FSM state encodings for the host-side UART link controller.
package uart_link_pkg;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_START,
    TX_WAIT_DONE
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_WAIT_CLR
  } rx_state_t;
endpackage

// File: rtl/uart_link_if.sv
// Host and UART parallel-interface signals of the link controller.
// master = controller view, slave = host/UART environment view.
interface uart_link_if;
  import uart_link_pkg::*;

  logic [BYTE_W-1:0] hostTxData;
  logic              hostTxValid;
  logic              hostTxReady;
  logic [BYTE_W-1:0] hostRxData;
  logic              hostRxValid;
  logic              hostRxReady;
  logic              clearErrors;
  logic              txTimeout;
  logic              rxDropped;
  logic              rxOverrun;
  logic [BYTE_W-1:0] uartTxData;
  logic              uartTxRequest;
  logic              uartTxActive;
  logic [BYTE_W-1:0] uartRxData;
  logic              uartDataRecv;
  logic              uartOverrun;
  logic              uartClearDR;

  modport master (
    input  hostTxData, hostTxValid, hostRxReady, clearErrors,
           uartTxActive, uartRxData, uartDataRecv, uartOverrun,
    output hostTxReady, hostRxData, hostRxValid, txTimeout, rxDropped, rxOverrun,
           uartTxData, uartTxRequest, uartClearDR
  );

  modport slave (
    output hostTxData, hostTxValid, hostRxReady, clearErrors,
           uartTxActive, uartRxData, uartDataRecv, uartOverrun,
    input  hostTxReady, hostRxData, hostRxValid, txTimeout, rxDropped, rxOverrun,
           uartTxData, uartTxRequest, uartClearDR
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word fall-through; head reads as zero while empty.
module uart_byte_fifo
  import uart_link_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/uart_link_controller.sv
// Host-side UART link: TX FIFO paced by txActive with ack timeout, RX capture
// acknowledged by clearDR into an RX FIFO, sticky error flags.
module uart_link_controller
  import uart_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input logic        masterClock,
  input logic        reset,
  uart_link_if.master bus
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] r_txActive_sync;
  logic [SYNC_STAGES-1:0] r_dataRecv_sync;
  logic [SYNC_STAGES-1:0] r_overrun_sync;
  logic w_txActive_s;
  logic w_dataRecv_s;
  logic w_overrun_s;

  tx_state_t         r_tx_state, w_tx_next;
  rx_state_t         r_rx_state, w_rx_next;
  logic [TW-1:0]     r_tx_timer;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_req;
  logic              w_tx_pop;
  logic              w_tx_timeout;
  logic [BYTE_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;

  logic [BYTE_W-1:0] r_rx_byte;
  logic              r_rx_push;
  logic              r_clearDR;
  logic              w_rx_capture;
  logic              w_rx_drop;
  logic              w_rx_full;
  logic              w_rx_empty;

  logic r_txTimeout;
  logic r_rxDropped;
  logic r_rxOverrun;

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      r_txActive_sync <= '0;
      r_dataRecv_sync <= '0;
      r_overrun_sync  <= '0;
    end else begin
      r_txActive_sync <= {r_txActive_sync[SYNC_STAGES-2:0], bus.uartTxActive};
      r_dataRecv_sync <= {r_dataRecv_sync[SYNC_STAGES-2:0], bus.uartDataRecv};
      r_overrun_sync  <= {r_overrun_sync[SYNC_STAGES-2:0], bus.uartOverrun};
    end
  end

  assign w_txActive_s = r_txActive_sync[SYNC_STAGES-1];
  assign w_dataRecv_s = r_dataRecv_sync[SYNC_STAGES-1];
  assign w_overrun_s  = r_overrun_sync[SYNC_STAGES-1];

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (masterClock),
    .rst     (reset),
    .i_push  (bus.hostTxValid),
    .i_data  (bus.hostTxData),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (masterClock),
    .rst     (reset),
    .i_push  (r_rx_push),
    .i_data  (r_rx_byte),
    .i_pop   (bus.hostRxReady),
    .o_data  (bus.hostRxData),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_tx_next    = r_tx_state;
    w_tx_pop     = 1'b0;
    w_tx_timeout = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_next = TX_WAIT_START;
      end
      TX_WAIT_START: begin
        if (w_txActive_s) begin
          w_tx_next = TX_WAIT_DONE;
        end else if (r_tx_timer == TW'(ACK_TIMEOUT)) begin
          w_tx_timeout = 1'b1;
          w_tx_next    = TX_IDLE;
        end
      end
      TX_WAIT_DONE: if (!w_txActive_s) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_rx_capture = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (w_dataRecv_s) begin
        w_rx_capture = 1'b1;
        w_rx_next    = RX_WAIT_CLR;
      end
      RX_WAIT_CLR: if (!w_dataRecv_s) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // Fullness is judged at capture; only pops can occur before the staged push lands.
  assign w_rx_drop = w_rx_capture & w_rx_full;

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      r_tx_state  <= TX_IDLE;
      r_rx_state  <= RX_IDLE;
      r_tx_timer  <= '0;
      r_tx_data   <= '0;
      r_tx_req    <= 1'b0;
      r_rx_byte   <= '0;
      r_rx_push   <= 1'b0;
      r_clearDR   <= 1'b0;
      r_txTimeout <= 1'b0;
      r_rxDropped <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
      r_tx_req   <= w_tx_pop;
      if (w_tx_pop) begin
        r_tx_data  <= w_tx_head;
        r_tx_timer <= '0;
      end else if (r_tx_state == TX_WAIT_START && w_tx_next == TX_WAIT_START) begin
        r_tx_timer <= r_tx_timer + 1'b1;
      end
      r_clearDR <= w_rx_capture;
      r_rx_push <= w_rx_capture & ~w_rx_full;
      if (w_rx_capture) r_rx_byte <= bus.uartRxData;
      r_txTimeout <= w_tx_timeout | (r_txTimeout & ~bus.clearErrors);
      r_rxDropped <= w_rx_drop    | (r_rxDropped & ~bus.clearErrors);
      r_rxOverrun <= w_overrun_s  | (r_rxOverrun & ~bus.clearErrors);
    end
  end

  assign bus.hostTxReady   = ~w_tx_full;
  assign bus.hostRxValid   = ~w_rx_empty;
  assign bus.uartTxData    = r_tx_data;
  assign bus.uartTxRequest = r_tx_req;
  assign bus.uartClearDR   = r_clearDR;
  assign bus.txTimeout     = r_txTimeout;
  assign bus.rxDropped     = r_rxDropped;
  assign bus.rxOverrun     = r_rxOverrun;
endmodule
